// File: rtl/fixed_to_float_pipe.sv
// ---------------------------------------------------------------------------
// fixed_to_float_pipe
//
// Three-stage pipelined converter from a fixed-point word (unsigned or two's
// complement, FRAC_W fraction bits) to an IEEE-754 single-precision value.
// Accepts one operand per clock and stays correct under downstream stalls.
//
// Stages:
//   S1 capture   : sign extraction, magnitude, zero flag
//   S2 normalise : leading-zero count, left-justify magnitude, biased exponent
//   S3 pack      : mantissa select, optional round-to-nearest-even, packing
//
// Parameters:
//   IN_W    input word width (2..32)
//   FRAC_W  fraction bits of the input (0..IN_W-1), 1.0 == 2**FRAC_W
//   SIGNED  0: unsigned input, 1: two's complement input
//   ROUND   0: truncate mantissa, 1: round-to-nearest-even (IN_W > 24 only)
//
// Ports:
//   clk        in   1     clock, rising edge
//   reset_n    in   1     asynchronous active-low reset
//   in_valid   in   1     in_fixed carries an operand
//   in_ready   out  1     pipeline can accept an operand
//   in_fixed   in   IN_W  fixed-point operand
//   out_valid  out  1     out_float carries a result
//   out_ready  in   1     consumer takes the result
//   out_float  out  32    {sign, exp[7:0], man[22:0]}
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both 1 on that interface. A producer holding valid keeps its data stable
// until the transfer; valid never depends on ready. Here in_ready is the
// only combinational path (from out_ready and out_valid).
// ---------------------------------------------------------------------------
module fixed_to_float_pipe #(
    parameter int IN_W   = 22,
    parameter int FRAC_W = 21,
    parameter int SIGNED = 0,
    parameter int ROUND  = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_fixed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_float
);

    localparam int LZW = $clog2(IN_W);
    // Fraction bits left once the leading one has been normalised away.
    localparam int FN  = IN_W - 1;
    // Fraction padded with 25 zeros so a 23-bit mantissa, a guard bit and
    // at least one sticky bit always exist, whatever IN_W is.
    localparam int FW  = FN + 25;
    localparam logic [8:0] EBIAS9 = 9'(127 + IN_W - 1 - FRAC_W);

    // Whole pipe advances together; only a held output blocks it.
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    function automatic logic [LZW-1:0] count_lz(input logic [IN_W-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + LZW'(1);
                end
            end
        end
        return n;
    endfunction

    // ---------------- S1 capture (combinational part) ----------------
    logic            in_sign;
    logic [IN_W-1:0] in_mag;

    always_comb begin
        in_sign = (SIGNED != 0) ? in_fixed[IN_W-1] : 1'b0;
        // IN_W-bit negate: the most negative input wraps to 2**(IN_W-1),
        // which is exactly its magnitude read as unsigned.
        in_mag  = in_sign ? (~in_fixed + IN_W'(1)) : in_fixed;
    end

    logic            s1_valid;
    logic            s1_sign;
    logic            s1_zero;
    logic [IN_W-1:0] s1_mag;

    // ---------------- S2 normalise (combinational part) ----------------
    logic [LZW-1:0] s1_lz;
    logic [8:0]     s1_exp;

    always_comb begin
        s1_lz  = count_lz(s1_mag);
        s1_exp = EBIAS9 - {{(9 - LZW){1'b0}}, s1_lz};
    end

    logic          s2_valid;
    logic          s2_sign;
    logic          s2_zero;
    logic [FN-1:0] s2_frac;
    logic [8:0]    s2_exp;

    // ---------------- S3 pack (combinational part) ----------------
    logic [FW-1:0] frac_ext;
    logic [22:0]   man_trunc;
    logic          guard_bit;
    logic          sticky_bit;
    logic          do_round;
    logic [23:0]   man_sum;
    logic [7:0]    exp_out;
    logic [31:0]   pack_float;

    always_comb begin
        frac_ext   = {s2_frac, 25'b0};
        man_trunc  = frac_ext[FW-1 -: 23];
        guard_bit  = frac_ext[FW-24];
        sticky_bit = |frac_ext[FW-25:0];
        do_round   = 1'b0;
        if ((ROUND != 0) && (IN_W > 24)) begin
            do_round = guard_bit & (sticky_bit | man_trunc[0]);
        end
        // A carry out of the mantissa leaves man_sum[22:0] == 0 and bumps
        // the exponent, which is exactly the renormalised result.
        man_sum    = {1'b0, man_trunc} + {23'b0, do_round};
        exp_out    = 8'(s2_exp + {8'b0, man_sum[23]});
        pack_float = s2_zero ? 32'h0000_0000 : {s2_sign, exp_out, man_sum[22:0]};
    end

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_mag    <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b0;
            s2_frac   <= '0;
            s2_exp    <= '0;
            out_valid <= 1'b0;
            out_float <= 32'h0000_0000;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s1_sign   <= in_sign;
            s1_zero   <= (in_mag == '0);
            s1_mag    <= in_mag;

            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_zero   <= s1_zero;
            // Leading one lands at IN_W-1 and is implicit, so drop it.
            s2_frac   <= FN'(s1_mag << s1_lz);
            s2_exp    <= s1_exp;

            out_valid <= s2_valid;
            out_float <= pack_float;
        end
    end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// ---------------------------------------------------------------------------
// Bench for fixed_to_float_pipe. Four instances share clock, reset, flow
// control and a 32-bit operand bus, each with a different parameter set:
//   lane0: IN_W=22 FRAC_W=21 unsigned, round
//   lane1: IN_W=22 FRAC_W=21 signed,   round
//   lane2: IN_W=32 FRAC_W=0  unsigned, round
//   lane3: IN_W=32 FRAC_W=0  unsigned, truncate
// Expected results come from an integer model of the float format.
// ---------------------------------------------------------------------------
module tb_fixed_to_float_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] din;

    logic        in_ready0, in_ready1, in_ready2, in_ready3;
    logic        out_valid0, out_valid1, out_valid2, out_valid3;
    logic [31:0] of0, of1, of2, of3;

    always #5 clk = ~clk;

    fixed_to_float_pipe #(.IN_W(22), .FRAC_W(21), .SIGNED(0), .ROUND(1)) u_lane0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_fixed(din[21:0]), .out_valid(out_valid0), .out_ready(out_ready), .out_float(of0));
    fixed_to_float_pipe #(.IN_W(22), .FRAC_W(21), .SIGNED(1), .ROUND(1)) u_lane1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_fixed(din[21:0]), .out_valid(out_valid1), .out_ready(out_ready), .out_float(of1));
    fixed_to_float_pipe #(.IN_W(32), .FRAC_W(0), .SIGNED(0), .ROUND(1)) u_lane2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_fixed(din), .out_valid(out_valid2), .out_ready(out_ready), .out_float(of2));
    fixed_to_float_pipe #(.IN_W(32), .FRAC_W(0), .SIGNED(0), .ROUND(0)) u_lane3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready3),
        .in_fixed(din), .out_valid(out_valid3), .out_ready(out_ready), .out_float(of3));

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];

    bit          obs_in_ready;
    bit          obs_out_valid;
    bit          obs_acc;
    logic [31:0] obs_out;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_float(input logic [31:0] raw, input int in_w,
                                              input int frac_w, input bit sgn_mode,
                                              input bit rnd);
        longint mag, man, rem, half;
        int     p, e, sh;
        bit     s;
        mag = longint'(raw) & ((longint'(1) << in_w) - 1);
        s   = 1'b0;
        if (sgn_mode && mag[in_w-1]) begin
            s   = 1'b1;
            mag = (longint'(1) << in_w) - mag;
        end
        if (mag == 0) return 32'h0000_0000;
        p = 0;
        for (int i = 0; i < 33; i++) if (mag[i]) p = i;
        e = 127 + p - frac_w;
        if (p <= 23) begin
            man = mag << (23 - p);
        end else begin
            sh   = p - 23;
            man  = mag >> sh;
            rem  = mag & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            if (rnd && ((rem > half) || ((rem == half) && man[0]))) man = man + 1;
            if (man == (longint'(1) << 24)) begin
                man = man >> 1;
                e   = e + 1;
            end
        end
        return {s, 8'(e), man[22:0]};
    endfunction

    function automatic logic [127:0] ref_lanes(input logic [31:0] d);
        return {ref_float(d, 22, 21, 1'b0, 1'b1), ref_float(d, 22, 21, 1'b1, 1'b1),
                ref_float(d, 32, 0, 1'b0, 1'b1), ref_float(d, 32, 0, 1'b0, 1'b0)};
    endfunction

    function automatic logic [31:0] lane(input logic [127:0] v, input int i);
        return v[(3 - i) * 32 +: 32];
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge; drives one cycle, records handshakes seen
    // just before the next rising edge, returns at the next falling edge.
    task automatic drive_cycle(input bit v, input logic [31:0] d, input bit ordy);
        in_valid  = v;
        din       = d;
        out_ready = ordy;
        #1;
        obs_in_ready  = in_ready0;
        obs_out_valid = out_valid0;
        obs_out       = of0;
        obs_acc       = v && in_ready0;
        if (out_valid0 && ordy) got_q.push_back({of0, of1, of2, of3});
        if (obs_acc) exp_q.push_back(ref_lanes(d));
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din       = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid0, out_valid1, out_valid2, out_valid3} !== 4'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0000",
                     {out_valid0, out_valid1, out_valid2, out_valid3});
        end
        checks++;
        if ({of0, of1, of2, of3} !== 128'h0) begin
            failures++;
            $display("FAIL reset_out_float got=%h exp=0", {of0, of1, of2, of3});
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready0, in_ready1, in_ready2, in_ready3} !== 4'b1111) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1111",
                     {in_ready0, in_ready1, in_ready2, in_ready3});
        end
    endtask

    task automatic test_latency();
        int n;
        in_valid  = 1'b1;
        din       = 32'h0020_0000;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL latency_accept got=%b exp=1", in_ready0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL latency_cycles got=%0d exp=3", n);
        end
        checks++;
        if (of0 !== 32'h3F80_0000) begin
            failures++;
            $display("FAIL latency_one got=%h exp=3f800000", of0);
        end
        checks++;
        if (of1 !== 32'hBF80_0000) begin
            failures++;
            $display("FAIL latency_minus_one got=%h exp=bf800000", of1);
        end
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b0) begin
            failures++;
            $display("FAIL latency_drain got=%b exp=0", out_valid0);
        end
    endtask

    task automatic test_directed();
        logic [31:0] dir_din[14];
        int          dir_lane[14];
        logic [31:0] dir_exp[14];
        dir_din[0]  = 32'h0000_0000; dir_lane[0]  = 0; dir_exp[0]  = 32'h0000_0000;
        dir_din[1]  = 32'h0020_0000; dir_lane[1]  = 0; dir_exp[1]  = 32'h3F80_0000;
        dir_din[2]  = 32'h0010_0000; dir_lane[2]  = 0; dir_exp[2]  = 32'h3F00_0000;
        dir_din[3]  = 32'h003F_FFFF; dir_lane[3]  = 0; dir_exp[3]  = 32'h3FFF_FFFC;
        dir_din[4]  = 32'h0000_0001; dir_lane[4]  = 0; dir_exp[4]  = 32'h3500_0000;
        dir_din[5]  = 32'h003F_FFFF; dir_lane[5]  = 1; dir_exp[5]  = 32'hB500_0000;
        dir_din[6]  = 32'h0020_0000; dir_lane[6]  = 1; dir_exp[6]  = 32'hBF80_0000;
        dir_din[7]  = 32'h0030_0000; dir_lane[7]  = 1; dir_exp[7]  = 32'hBF00_0000;
        dir_din[8]  = 32'h0000_0000; dir_lane[8]  = 1; dir_exp[8]  = 32'h0000_0000;
        dir_din[9]  = 32'h0100_0001; dir_lane[9]  = 2; dir_exp[9]  = 32'h4B80_0000;
        dir_din[10] = 32'h0100_0003; dir_lane[10] = 2; dir_exp[10] = 32'h4B80_0002;
        dir_din[11] = 32'hFFFF_FFFF; dir_lane[11] = 2; dir_exp[11] = 32'h4F80_0000;
        dir_din[12] = 32'hFFFF_FFFF; dir_lane[12] = 3; dir_exp[12] = 32'h4F7F_FFFF;
        dir_din[13] = 32'h0010_0000; dir_lane[13] = 1; dir_exp[13] = 32'h3F00_0000;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 14; i++) drive_cycle(1'b1, dir_din[i], 1'b1);
        repeat (6) drive_cycle(1'b0, 32'h0, 1'b1);
        checks++;
        if (got_q.size() != 14) begin
            failures++;
            $display("FAIL directed_count got=%0d exp=14", got_q.size());
        end
        for (int i = 0; i < 14 && i < got_q.size(); i++) begin
            checks++;
            if (lane(got_q[i], dir_lane[i]) !== dir_exp[i]) begin
                failures++;
                $display("FAIL directed item%0d lane%0d in=%h got=%h exp=%h", i, dir_lane[i],
                         dir_din[i], lane(got_q[i], dir_lane[i]), dir_exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[6];
        logic [31:0] held;
        int          sent;
        bit          ordy;
        for (int i = 0; i < 6; i++) vals[i] = $urandom;
        exp_q.delete();
        got_q.delete();
        sent = 0;
        held = '0;
        for (int c = 0; c < 40; c++) begin
            ordy = !(c >= 4 && c < 8);
            drive_cycle(sent < 6, (sent < 6) ? vals[sent] : 32'h0, ordy);
            if (obs_acc) sent++;
            if (!ordy) begin
                checks++;
                if (obs_in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_in_ready cycle%0d got=%b exp=0", c, obs_in_ready);
                end
                checks++;
                if (obs_out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_out_valid cycle%0d got=%b exp=1", c, obs_out_valid);
                end
                if (c == 4) begin
                    held = obs_out;
                end else begin
                    checks++;
                    if (obs_out !== held) begin
                        failures++;
                        $display("FAIL stall_stable cycle%0d got=%h exp=%h", c, obs_out, held);
                    end
                end
            end
        end
        checks++;
        if (got_q.size() != 6 || exp_q.size() != 6) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=6 accepted=%0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            for (int l = 0; l < 4; l++) begin
                checks++;
                if (lane(got_q[k], l) !== lane(exp_q[k], l)) begin
                    failures++;
                    $display("FAIL b2b item%0d lane%0d got=%h exp=%h", k, l,
                             lane(got_q[k], l), lane(exp_q[k], l));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int  acc;
        bit  seen;
        exp_q.delete();
        got_q.delete();
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, $urandom, 1'b0);
            if (obs_acc) acc++;
        end
        checks++;
        if (acc != 3) begin
            failures++;
            $display("FAIL midreset_accepts got=%0d exp=3", acc);
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        checks++;
        if (out_valid0 !== 1'b0 || of0 !== 32'h0) begin
            failures++;
            $display("FAIL midreset_clear got=%b/%h exp=0/00000000", out_valid0, of0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b1);
            if (obs_out_valid) seen = 1'b1;
        end
        checks++;
        if (seen || got_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_stale got=%0d exp=0", got_q.size());
        end
        drive_cycle(1'b1, 32'h0008_0000, 1'b1);
        repeat (5) drive_cycle(1'b0, 32'h0, 1'b1);
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            failures++;
            $display("FAIL midreset_resume got=%0d exp=1", got_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL midreset_resume got=%h exp=%h", got_q[0], exp_q[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        bit          v;
        bit          ordy;
        exp_q.delete();
        got_q.delete();
        for (int c = 0; c < 400; c++) begin
            v    = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < 75);
            case ($urandom_range(0, 7))
                0:       d = 32'h0;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'd1 << $urandom_range(0, 31);
                3:       d = $urandom & 32'h00FF_FFFF;
                4:       d = (32'h0100_0000 | 32'($urandom_range(0, 3))) << $urandom_range(0, 7);
                5:       d = 32'h0020_0000 | 32'($urandom_range(0, 15));
                default: d = $urandom;
            endcase
            drive_cycle(v, d, ordy);
        end
        repeat (10) drive_cycle(1'b0, 32'h0, 1'b1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            for (int l = 0; l < 4; l++) begin
                checks++;
                if (lane(got_q[k], l) !== lane(exp_q[k], l)) begin
                    failures++;
                    $display("FAIL random item%0d lane%0d got=%h exp=%h", k, l,
                             lane(got_q[k], l), lane(exp_q[k], l));
                end
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din       = '0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
